regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (we3/wa3/wd3) among three sources:
//  - ALU writeback: fixed highest priority, no backpressure.
//  - Load writeback: valid/ready, buffered in a DEPTH-entry FIFO.
//  - Debug writes: valid/ready, lowest priority, with starvation escape.

---
 rtl/regarb_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_queue.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// Shared types for the register-file write-port arbiter: queued write request,
// debug-starvation FSM states and the never-written PC register index.
package regarb_pkg;

  localparam int WB_DW = 32;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0]       wa;
    logic [WB_DW-1:0] wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    DBG_IDLE  = 2'd0,
    DBG_WAIT  = 2'd1,
    DBG_FORCE = 2'd2
  } dbg_state_t;

  function automatic logic [15:0] reg_onehot(input logic [3:0] wa);
    reg_onehot = 16'd1 << wa;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_queue.sv
// wb_queue: synchronous FIFO of load writebacks. Exposes every slot and its
// valid bit so the parent can build the pending-register mask.
module wb_queue
  import regarb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   ent,
  output logic [DEPTH-1:0]      vld
);

  wb_req_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]    vld_q;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       cnt_q;
  logic                do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        vld_q[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        vld_q[rd_ptr] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= push_req;
  end

  assign head  = mem_q[rd_ptr];
  assign count = cnt_q;
  assign ent   = mem_q;
  assign vld   = vld_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between ALU (fixed top priority), a load
// queue and debug writes with starvation escape. REGFILE_ARB_STATS_EN adds stat_defer_cnt.
module regfile_wb_arbiter
  import regarb_pkg::*;
#(
  parameter int DW           = WB_DW,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_we,
  input  logic [3:0]    alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [3:0]    mem_wa,
  input  logic [DW-1:0] mem_wd,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [3:0]    dbg_wa,
  input  logic [DW-1:0] dbg_wd,
  output logic          we3,
  output logic [3:0]    wa3,
  output logic [DW-1:0] wd3,
  output logic [15:0]   pend_mask,
  output logic [CW-1:0] q_count,
`ifdef REGFILE_ARB_STATS_EN
  output dbg_state_t    dbg_fsm,
  output logic [15:0]   stat_defer_cnt
`else
  output dbg_state_t    dbg_fsm
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);

  // Handshakes: a load transfers on mem_valid && mem_ready, a debug write on
  // dbg_valid && dbg_ready; requesters hold payload stable until the transfer.
  wb_req_t             q_head;
  wb_req_t [DEPTH-1:0] q_ent;
  logic [DEPTH-1:0]    q_vld;
  logic                q_push, q_pop, q_full, q_empty;
  dbg_state_t          state_q, state_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                dbg_grant;

  assign mem_ready = !q_full;
  // A load to the PC is acknowledged but dropped.
  assign q_push    = mem_valid && mem_ready && (mem_wa != REG_PC);

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_req ('{wa: mem_wa, wd: mem_wd}),
    .pop      (q_pop),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty),
    .ent      (q_ent),
    .vld      (q_vld)
  );

  // Write-port select; nothing is written in a reset cycle so discarded loads never land.
  always_comb begin
    we3       = 1'b0;
    wa3       = '0;
    wd3       = '0;
    dbg_ready = 1'b0;
    q_pop     = 1'b0;
    if (!reset) begin
      if (alu_we) begin
        if (alu_wa != REG_PC) begin
          we3 = 1'b1;
          wa3 = alu_wa;
          wd3 = alu_wd;
        end
      end else if (state_q == DBG_FORCE || q_empty) begin
        dbg_ready = 1'b1;
        if (dbg_valid && dbg_wa != REG_PC) begin
          we3 = 1'b1;
          wa3 = dbg_wa;
          wd3 = dbg_wd;
        end
      end else begin
        q_pop = 1'b1;
        we3   = 1'b1;
        wa3   = q_head.wa;
        wd3   = q_head.wd;
      end
    end
  end

  assign dbg_grant = dbg_valid && dbg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DBG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts cycles debug has waited; reaching STARVE_LIMIT lets it outrank the queue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!dbg_valid) begin
      state_d = DBG_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DBG_IDLE: begin
          if (!dbg_ready) begin
            cnt_d   = SW'(1);
            state_d = (STARVE_LIMIT <= 1) ? DBG_FORCE : DBG_WAIT;
          end
        end
        DBG_WAIT: begin
          if (dbg_grant) begin
            state_d = DBG_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d >= SW'(STARVE_LIMIT)) state_d = DBG_FORCE;
          end
        end
        DBG_FORCE: begin
          if (dbg_grant) begin
            state_d = DBG_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = DBG_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dbg_fsm = state_q;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pend_mask = pend_mask | reg_onehot(q_ent[i].wa);
    end
    pend_mask[REG_PC] = 1'b0;
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_defer_cnt <= '0;
    end else if (!q_empty && !q_pop && stat_defer_cnt != 16'hFFFF) begin
      stat_defer_cnt <= stat_defer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with a write
// scoreboard (exp_q) checked on every regfile write.
module tb_regfile_wb_arbiter;
  import regarb_pkg::*;

  localparam int DW           = 32;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CW           = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          alu_we;
  logic [3:0]    alu_wa;
  logic [DW-1:0] alu_wd;
  logic          mem_valid;
  logic          mem_ready;
  logic [3:0]    mem_wa;
  logic [DW-1:0] mem_wd;
  logic          dbg_valid;
  logic          dbg_ready;
  logic [3:0]    dbg_wa;
  logic [DW-1:0] dbg_wd;
  logic          we3;
  logic [3:0]    wa3;
  logic [DW-1:0] wd3;
  logic [15:0]   pend_mask;
  logic [CW-1:0] q_count;
  dbg_state_t    dbg_fsm;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0]   stat_defer_cnt;
`endif

  logic [DW+3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DW(DW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_we    (alu_we),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_wa    (dbg_wa),
    .dbg_wd    (dbg_wd),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .pend_mask (pend_mask),
    .q_count   (q_count),
`ifdef REGFILE_ARB_STATS_EN
    .dbg_fsm   (dbg_fsm),
    .stat_defer_cnt (stat_defer_cnt)
`else
    .dbg_fsm   (dbg_fsm)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver helpers: inputs change 1ns after the rising edge, checks at the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // scoreboard: every regfile write must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && we3) begin
      if (exp_q.size() == 0) begin
        check("write_unexpected", {63'd0, we3}, 64'd0);
      end else begin
        check("wb_write", {28'd0, wa3, wd3}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : stim
    logic [DW+3:0] lq[$];
    logic [DW+3:0] held[$];
    logic [DW+3:0] l4;
    int exp_cnt[6];
    int t6_wa[3];
    exp_cnt = '{4, 3, 3, 2, 1, 0};
    t6_wa   = '{2, 5, 7};

    reset = 1'b1; alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    dbg_valid = 1'b0; dbg_wa = '0; dbg_wd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state
    settle();
    check("rst_we3", we3, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_pend_mask", pend_mask, 0);
    check("rst_q_count", q_count, 0);
    check("rst_fsm", dbg_fsm, DBG_IDLE);

    // 2: single load, latency one cycle
    next_cycle();
    mem_valid = 1'b1; mem_wa = 4'd3; mem_wd = 32'hAAAA_0001;
    exp_q.push_back({4'd3, 32'hAAAA_0001});
    settle();
    check("t2_ready", mem_ready, 1);
    check("t2_pend_t0", pend_mask, 0);
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check("t2_pend_t1", pend_mask, 16'h0008);
    check("t2_we3_t1", we3, 1);
    check("t2_wa3_t1", wa3, 3);
    check("t2_wd3_t1", wd3, 32'hAAAA_0001);
    next_cycle();
    settle();
    check("t2_pend_t2", pend_mask, 0);
    check("t2_q_count_t2", q_count, 0);

    // 3: ALU every cycle blocks the queue until it fills
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      alu_we = 1'b1; alu_wa = 4'd1; alu_wd = $urandom;
      exp_q.push_back({alu_wa, alu_wd});
      mem_valid = 1'b1; mem_wa = 4'(4 + i); mem_wd = $urandom;
      if (i < 4) lq.push_back({mem_wa, mem_wd});
      settle();
      check("t3_fill_ready", mem_ready, (i < 4));
      if (i == 4) begin
        check("t3_full_count", q_count, 4);
        check("t3_full_pend", pend_mask, 16'h00F0);
      end
    end
    l4 = {mem_wa, mem_wd};
    while (lq.size() > 0) exp_q.push_back(lq.pop_front());
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      alu_we = 1'b0;
      if (j == 1) exp_q.push_back(l4);
      if (j == 2) mem_valid = 1'b0;
      settle();
      check("t3_drain_count", q_count, exp_cnt[j]);
      check("t3_drain_ready", mem_ready, (j != 0));
      check("t3_drain_we3", we3, (j < 5));
    end

    // 4: debug starved by a queue kept non-empty
    dbg_wa = 4'd6; dbg_wd = $urandom;
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      mem_valid = (k <= 9);
      if (k <= 9) begin
        mem_wa = 4'd9; mem_wd = $urandom;
        if (k < 8) exp_q.push_back({mem_wa, mem_wd});
        else held.push_back({mem_wa, mem_wd});
      end
      dbg_valid = (k >= 1 && k <= 9);
      if (k == 9) begin
        exp_q.push_back({dbg_wa, dbg_wd});
        while (held.size() > 0) exp_q.push_back(held.pop_front());
      end
      settle();
      if (k >= 1 && k <= 9) check("t4_dbg_ready", dbg_ready, (k == 9));
      if (k == 9) check("t4_fsm_force", dbg_fsm, DBG_FORCE);
      if (k == 10) check("t4_fsm_idle", dbg_fsm, DBG_IDLE);
      if (k == 5) check("t4_pend", pend_mask, 16'h0200);
      check("t4_q_count", q_count, (k == 0) ? 0 : (k == 10) ? 2 : 1);
    end
    next_cycle();
    settle();
    check("t4_drained", q_count, 0);

    // 5: R15 is never written
    next_cycle();
    alu_we = 1'b1; alu_wa = 4'd15; alu_wd = $urandom;
    settle();
    check("t5_alu_we3", we3, 0);
    next_cycle();
    alu_we = 1'b0; dbg_valid = 1'b1; dbg_wa = 4'd15; dbg_wd = $urandom;
    settle();
    check("t5_dbg_ready", dbg_ready, 1);
    check("t5_dbg_we3", we3, 0);
    next_cycle();
    dbg_valid = 1'b0; mem_valid = 1'b1; mem_wa = 4'd15; mem_wd = $urandom;
    settle();
    check("t5_mem_ready", mem_ready, 1);
    check("t5_mem_we3", we3, 0);
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check("t5_q_count", q_count, 0);
    check("t5_pend", pend_mask, 0);

    // 6: reset discards queued loads and dominates a same-cycle enqueue
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      alu_we = 1'b1; alu_wa = 4'd1; alu_wd = $urandom;
      exp_q.push_back({alu_wa, alu_wd});
      mem_valid = 1'b1; mem_wa = 4'(t6_wa[i]); mem_wd = $urandom_range(1, 32'hFFFF);
    end
    next_cycle();
    alu_we = 1'b0; mem_valid = 1'b1; mem_wa = 4'd3; reset = 1'b1;
    settle();
    check("t6_pre_count", q_count, 3);
    check("t6_pre_pend", pend_mask, 16'h00A4);
    check("t6_rst_we3", we3, 0);
    next_cycle();
    reset = 1'b0; mem_valid = 1'b0;
    settle();
    check("t6_q_count", q_count, 0);
    check("t6_pend", pend_mask, 0);
    check("t6_mem_ready", mem_ready, 1);
    check("t6_we3", we3, 0);
    check("t6_fsm", dbg_fsm, DBG_IDLE);
    repeat (3) next_cycle();
    settle();

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
